// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Two-port round-robin arbiter/sequencer for a 16x4 register file.
// Rev     : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int REGISTER_WIDTH       = 4,
    parameter int MEMORY_ADDRESS_WIDTH = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            req0_i,
    input  logic                            req1_i,
    input  logic                            we0_i,
    input  logic                            we1_i,
    input  logic [MEMORY_ADDRESS_WIDTH-1:0] addr0_i,
    input  logic [MEMORY_ADDRESS_WIDTH-1:0] addr1_i,
    input  logic [REGISTER_WIDTH-1:0]       wdata0_i,
    input  logic [REGISTER_WIDTH-1:0]       wdata1_i,
    output logic                            gnt0_o,
    output logic                            gnt1_o,
    output logic                            rvalid0_o,
    output logic                            rvalid1_o,
    output logic [REGISTER_WIDTH-1:0]       rdata_o,
    output logic                            mem_write_en_o,
    output logic                            mem_read_en_o,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [REGISTER_WIDTH-1:0]       mem_data_o,
    input  logic [REGISTER_WIDTH-1:0]       mem_data_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic                            winner_q, winner_d;
    logic                            we_q, we_d;
    logic [MEMORY_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [REGISTER_WIDTH-1:0]       wdata_q, wdata_d;
    logic                            last_grant_q, last_grant_d;
    logic                            gnt0_q, gnt0_d;
    logic                            gnt1_q, gnt1_d;
    logic                            wr_en_q, wr_en_d;
    logic                            rd_en_q, rd_en_d;
    logic                            rvalid0_q, rvalid0_d;
    logic                            rvalid1_q, rvalid1_d;
    logic [REGISTER_WIDTH-1:0]       rdata_q, rdata_d;
    logic                            win_sel;
    logic                            win_we;

    // On a tie the port that did not win last time takes the slot.
    always_comb begin
        win_sel = (req0_i && req1_i) ? ~last_grant_q : req1_i;
        win_we  = win_sel ? we1_i : we0_i;
    end

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        rdata_d      = rdata_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    winner_d     = win_sel;
                    we_d         = win_we;
                    addr_d       = win_sel ? addr1_i : addr0_i;
                    wdata_d      = win_sel ? wdata1_i : wdata0_i;
                    last_grant_d = win_sel;
                    gnt0_d       = ~win_sel;
                    gnt1_d       = win_sel;
                    wr_en_d      = win_we;
                    rd_en_d      = ~win_we;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                state_d = we_q ? IDLE : WAIT;
            end
            WAIT: begin
                rdata_d   = mem_data_i;
                rvalid0_d = ~winner_q;
                rvalid1_d = winner_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            winner_q     <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_grant_q <= 1'b1;
            rdata_q      <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            rdata_q      <= rdata_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
        end
    end

    assign gnt0_o         = gnt0_q;
    assign gnt1_o         = gnt1_q;
    assign rvalid0_o      = rvalid0_q;
    assign rvalid1_o      = rvalid1_q;
    assign rdata_o        = rdata_q;
    assign mem_write_en_o = wr_en_q;
    assign mem_read_en_o  = rd_en_q;
    assign mem_addr_o     = addr_q;
    assign mem_data_o     = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Self-checking bench for mem_arbiter with a register-file model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int DW = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          req0_i = 1'b0, req1_i = 1'b0;
    logic          we0_i = 1'b0, we1_i = 1'b0;
    logic [AW-1:0] addr0_i = '0, addr1_i = '0;
    logic [DW-1:0] wdata0_i = '0, wdata1_i = '0;
    logic          gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
    logic [DW-1:0] rdata_o;
    logic          mem_write_en_o, mem_read_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [DW-1:0] mem_data_i = '0;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mem[16];
    logic [DW-1:0] shadow[16];
    int            checks = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.REGISTER_WIDTH(DW), .MEMORY_ADDRESS_WIDTH(AW)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .rvalid0_o(rvalid0_o), .rvalid1_o(rvalid1_o),
        .rdata_o(rdata_o), .mem_write_en_o(mem_write_en_o), .mem_read_en_o(mem_read_en_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    // Register-file model: synchronous write, registered read.
    always @(posedge clk) begin
        if (mem_write_en_o) mem[mem_addr_o] <= mem_data_o;
        if (mem_read_en_o) mem_data_i <= mem[mem_addr_o];
    end

    // Read-return scoreboard and per-cycle exclusivity checks.
    always @(negedge clk) begin
        if (rvalid0_o || rvalid1_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rvalid_unexpected: got rv0=%0b rv1=%0b rdata=%h, required no rvalid", rvalid0_o, rvalid1_o, rdata_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({rvalid1_o, rvalid0_o, rdata_o} !== {e.port, ~e.port, e.data}) begin
                    fails++;
                    $display("FAIL read_return: got rv1=%0b rv0=%0b rdata=%h, required port%0d rdata=%h",
                             rvalid1_o, rvalid0_o, rdata_o, e.port, e.data);
                end
            end
        end
        if ((gnt0_o && gnt1_o) || (mem_write_en_o && mem_read_en_o)) begin
            checks++;
            fails++;
            $display("FAIL exclusive: got gnt=%b%b en=%b%b, required at most one of each",
                     gnt1_o, gnt0_o, mem_write_en_o, mem_read_en_o);
        end
    end

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending reads, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic issue(input bit port, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int n = 0;
        if (port) begin
            req1_i = 1'b1; we1_i = we; addr1_i = addr; wdata1_i = data;
        end else begin
            req0_i = 1'b1; we0_i = we; addr0_i = addr; wdata0_i = data;
        end
        if (!we) exp_q.push_back('{port: port, data: shadow[addr]});
        do begin
            @(negedge clk);
            n++;
        end while (!(port ? gnt1_o : gnt0_o) && n < 20);
        checks++;
        if (!(port ? gnt1_o : gnt0_o)) begin
            fails++;
            $display("FAIL grant_timeout: got no gnt%0d after %0d cycles, required a grant", port, n);
        end
        if (we) shadow[addr] = data;
        if (port) req1_i = 1'b0; else req0_i = 1'b0;
    endtask

    task automatic test_reset();
        req0_i = 1'b1; we0_i = 1'b1; addr0_i = 4'd0; wdata0_i = 4'd0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, mem_write_en_o, mem_read_en_o, rdata_o, mem_addr_o, mem_data_o} !== '0) begin
                fails++;
                $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b en=%b%b rdata=%h addr=%h data=%h, required all 0",
                         gnt1_o, gnt0_o, rvalid1_o, rvalid0_o, mem_write_en_o, mem_read_en_o, rdata_o, mem_addr_o, mem_data_o);
            end
        end
        reset_i = 1'b1;
        #1;
        checks++;
        if (gnt0_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_early: got gnt0=%b, required 0", gnt0_o);
        end
        @(negedge clk);
        checks++;
        if ({gnt0_o, mem_write_en_o} !== 2'b11) begin
            fails++;
            $display("FAIL reset_release_gnt: got gnt0=%b we=%b, required 1 1", gnt0_o, mem_write_en_o);
        end
        shadow[0] = 4'd0;
        req0_i = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt0_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_gnt_pulse: got gnt0=%b, required 0", gnt0_o);
        end
    endtask

    task automatic test_write_read();
        req0_i = 1'b1; we0_i = 1'b1; addr0_i = 4'd3; wdata0_i = 4'hA;
        @(negedge clk);
        checks++;
        if ({gnt0_o, gnt1_o, mem_write_en_o, mem_read_en_o, mem_addr_o, mem_data_o} !== {4'b1010, 4'd3, 4'hA}) begin
            fails++;
            $display("FAIL write_issue: got gnt=%b%b en=%b%b addr=%h data=%h, required gnt0 we addr=3 data=a",
                     gnt1_o, gnt0_o, mem_write_en_o, mem_read_en_o, mem_addr_o, mem_data_o);
        end
        shadow[3] = 4'hA;
        req0_i = 1'b0;
        @(negedge clk);
        req0_i = 1'b1; we0_i = 1'b0;
        exp_q.push_back('{port: 1'b0, data: shadow[3]});
        @(negedge clk);
        checks++;
        if ({gnt0_o, mem_write_en_o, mem_read_en_o, mem_addr_o} !== {3'b101, 4'd3}) begin
            fails++;
            $display("FAIL read_issue: got gnt0=%b en=%b%b addr=%h, required gnt0 re addr=3",
                     gnt0_o, mem_write_en_o, mem_read_en_o, mem_addr_o);
        end
        req0_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({rvalid0_o, mem_read_en_o} !== 2'b00) begin
            fails++;
            $display("FAIL read_wait: got rv0=%b re=%b, required 0 0", rvalid0_o, mem_read_en_o);
        end
        @(negedge clk);
        checks++;
        if ({rvalid0_o, rdata_o} !== {1'b1, 4'hA}) begin
            fails++;
            $display("FAIL read_latency: got rv0=%b rdata=%h, required 1 a", rvalid0_o, rdata_o);
        end
        drain();
    endtask

    task automatic test_contention();
        int order_ok = 1;
        int grants = 0;
        bit next_port;
        reset_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b1;
        req0_i = 1'b1; we0_i = 1'b1; addr0_i = 4'd1; wdata0_i = 4'd1;
        req1_i = 1'b1; we1_i = 1'b1; addr1_i = 4'd2; wdata1_i = 4'd2;
        @(negedge clk);
        checks++;
        if ({gnt0_o, gnt1_o, mem_addr_o} !== {2'b10, 4'd1}) begin
            fails++;
            $display("FAIL tie_first: got gnt=%b%b addr=%h, required gnt0 addr=1", gnt1_o, gnt0_o, mem_addr_o);
        end
        req0_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt0_o, gnt1_o, mem_addr_o} !== {2'b01, 4'd2}) begin
            fails++;
            $display("FAIL tie_second: got gnt=%b%b addr=%h, required gnt1 addr=2", gnt1_o, gnt0_o, mem_addr_o);
        end
        shadow[1] = 4'd1; shadow[2] = 4'd2;
        req0_i = 1'b1;
        next_port = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (gnt0_o || gnt1_o) begin
                grants++;
                if (gnt1_o !== next_port) order_ok = 0;
                next_port = ~next_port;
            end
        end
        req0_i = 1'b0; req1_i = 1'b0;
        checks++;
        if (order_ok != 1 || grants < 6) begin
            fails++;
            $display("FAIL round_robin: got order_ok=%0d grants=%0d, required 1 and >=6", order_ok, grants);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_isolation();
        issue(1'b1, 1'b1, 4'd7, 4'h5);
        @(negedge clk);
        req1_i = 1'b1; we1_i = 1'b0; addr1_i = 4'd7;
        exp_q.push_back('{port: 1'b1, data: shadow[7]});
        @(negedge clk);
        checks++;
        if ({gnt1_o, gnt0_o, mem_read_en_o, mem_addr_o} !== {3'b101, 4'd7}) begin
            fails++;
            $display("FAIL iso_issue: got gnt=%b%b re=%b addr=%h, required gnt1 re addr=7", gnt1_o, gnt0_o, mem_read_en_o, mem_addr_o);
        end
        req1_i = 1'b0;
        req0_i = 1'b1; we0_i = 1'b0; addr0_i = 4'd3;
        exp_q.push_back('{port: 1'b0, data: shadow[3]});
        @(negedge clk);
        checks++;
        if ({gnt0_o, rvalid0_o} !== 2'b00) begin
            fails++;
            $display("FAIL iso_wait: got gnt0=%b rv0=%b, required 0 0", gnt0_o, rvalid0_o);
        end
        @(negedge clk);
        checks++;
        if ({rvalid1_o, rvalid0_o, gnt0_o, rdata_o} !== {3'b100, 4'h5}) begin
            fails++;
            $display("FAIL iso_return: got rv1=%b rv0=%b gnt0=%b rdata=%h, required 1 0 0 5", rvalid1_o, rvalid0_o, gnt0_o, rdata_o);
        end
        @(negedge clk);
        checks++;
        if (gnt0_o !== 1'b1) begin
            fails++;
            $display("FAIL iso_late_gnt: got gnt0=%b, required 1", gnt0_o);
        end
        req0_i = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid_read();
        req0_i = 1'b1; we0_i = 1'b0; addr0_i = 4'd3;
        @(negedge clk);
        checks++;
        if ({gnt0_o, mem_read_en_o} !== 2'b11) begin
            fails++;
            $display("FAIL mid_issue: got gnt0=%b re=%b, required 1 1", gnt0_o, mem_read_en_o);
        end
        req0_i = 1'b0;
        @(negedge clk);
        #2 reset_i = 1'b0;
        #1;
        checks++;
        if ({mem_read_en_o, rvalid0_o, gnt0_o, rdata_o} !== '0) begin
            fails++;
            $display("FAIL mid_reset: got re=%b rv0=%b gnt0=%b rdata=%h, required all 0", mem_read_en_o, rvalid0_o, gnt0_o, rdata_o);
        end
        repeat (2) @(negedge clk);
        reset_i = 1'b1;
        req0_i = 1'b1; we0_i = 1'b1; addr0_i = 4'd4; wdata0_i = 4'd1;
        req1_i = 1'b1; we1_i = 1'b1; addr1_i = 4'd5; wdata1_i = 4'd2;
        @(negedge clk);
        checks++;
        if ({gnt0_o, gnt1_o, rvalid0_o} !== 3'b100) begin
            fails++;
            $display("FAIL mid_tie: got gnt=%b%b rv0=%b, required gnt0 only", gnt1_o, gnt0_o, rvalid0_o);
        end
        shadow[4] = 4'd1;
        req0_i = 1'b0;
        req1_i = 1'b0;
        issue(1'b1, 1'b1, 4'd5, 4'd2);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 16; a++) issue(1'b1, 1'b1, 4'(a), ~4'(a));
        for (int a = 0; a < 16; a++) issue(1'b0, 1'b0, 4'(a), 4'd0);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end
        test_reset();
        test_write_read();
        test_contention();
        test_isolation();
        test_reset_mid_read();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
